// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder: MMIO register map and address regions.
package dmem_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned MMIO_W   = 16;

  localparam logic [MMIO_W-1:0] MMIO_CYCLE   = 16'h0000;
  localparam logic [MMIO_W-1:0] MMIO_TOHOST  = 16'h0001;
  localparam logic [MMIO_W-1:0] MMIO_SCRATCH = 16'h0002;

  typedef enum logic [1:0] {
    REGION_RAM  = 2'd0,
    REGION_MMIO = 2'd1,
    REGION_OOR  = 2'd2
  } region_e;

endpackage

// File: rtl/dmem_ram.sv
// Word-addressed RAM: one asynchronous read port, one synchronous write port, contents not reset.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_W-1:0]     rdata_c
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read before write: a same-word write only becomes visible after the edge.
  assign rdata_c = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the core's MEM stage: RAM, MMIO registers (cycle, tohost, scratch)
// and out-of-range detection, with a bench preload port that wins over core stores.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned     DEPTH_LOG2 = 10,
  parameter logic [15:0]     MMIO_TAG   = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  memwrite,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [DATA_W-1:0]     ld_data,
  output logic [DATA_W-1:0]     rdata,
  output logic                  done,
  output logic [DATA_W-1:0]     exit_code,
  output logic                  err
);

  region_e              region;
  logic [MMIO_W-1:0]    mmio_off;
  logic [DEPTH_LOG2-1:0] ram_idx;
  logic                 ram_we;
  logic [DEPTH_LOG2-1:0] ram_waddr;
  logic [DATA_W-1:0]    ram_wdata;
  logic [DATA_W-1:0]    ram_rdata;
  logic [DATA_W-1:0]    cycle_q;
  logic [DATA_W-1:0]    scratch_q;
  logic                 tohost_wr;
  logic                 scratch_wr;

  assign mmio_off = addr[MMIO_W-1:0];
  assign ram_idx  = addr[DEPTH_LOG2-1:0];

  // RAM takes precedence in decode so a large DEPTH_LOG2 never aliases into MMIO.
  always_comb begin
    region = REGION_OOR;
    if ((addr >> DEPTH_LOG2) == '0) begin
      region = REGION_RAM;
    end else if (addr[ADDR_W-1:MMIO_W] == MMIO_TAG) begin
      region = REGION_MMIO;
    end
  end

  // Preload owns the write port whenever it is active; a concurrent core store is dropped.
  always_comb begin
    ram_we    = ld_en | (memwrite & (region == REGION_RAM));
    ram_waddr = ram_idx;
    ram_wdata = wdata;
    if (ld_en) begin
      ram_waddr = ld_addr;
      ram_wdata = ld_data;
    end
  end

  assign tohost_wr  = memwrite & (region == REGION_MMIO) & (mmio_off == MMIO_TOHOST);
  assign scratch_wr = memwrite & (region == REGION_MMIO) & (mmio_off == MMIO_SCRATCH);

  dmem_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .raddr   (ram_idx),
    .rdata_c (ram_rdata)
  );

  // Zero-latency read mux; unmapped and out-of-range reads return 0.
  always_comb begin
    rdata = '0;
    case (region)
      REGION_RAM: rdata = ram_rdata;
      REGION_MMIO: begin
        if (mmio_off == MMIO_CYCLE) begin
          rdata = cycle_q;
        end else if (mmio_off == MMIO_SCRATCH) begin
          rdata = scratch_q;
        end
      end
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_q   <= '0;
      scratch_q <= '0;
      done      <= 1'b0;
      exit_code <= '0;
      err       <= 1'b0;
    end else begin
      if (!done) begin
        cycle_q <= cycle_q + DATA_W'(1);
      end
      // Only the first tohost store is recorded; later ones are ignored.
      if (tohost_wr && !done) begin
        done      <= 1'b1;
        exit_code <= wdata;
      end
      if (scratch_wr) begin
        scratch_q <= wdata;
      end
      if (region == REGION_OOR) begin
        err <= 1'b1;
      end
    end
  end

endmodule
